pkt_frame_fsm: RTL and testbench

//  Parametrised packet-framing FSM tracking head/data/tail beats on one valid-qualified stream.

---
 rtl/pkt_frame_fsm_if.sv | 14 +
 rtl/pkt_frame_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_pkt_frame_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_frame_fsm_if.sv
// pkt_frame_fsm_if
//   Beat-qualifier bundle for one valid-qualified packet stream.
//   valid : beat qualifier, head/tail are ignored while low
//   head  : first beat of a packet
//   tail  : last beat of a packet
//   master drives the stream, slave (the framing FSM) observes it.
interface pkt_frame_fsm_if;
  logic valid;
  logic head;
  logic tail;

  modport master (output valid, output head, output tail);
  modport slave  (input  valid, input  head, input  tail);
endinterface

// File: rtl/pkt_frame_fsm.sv
// pkt_frame_fsm
//   Packet-framing FSM that tracks head/data/tail beats on one valid-qualified
//   stream. It counts beats, enforces a maximum packet length, detects and
//   reports protocol errors, and counts completed packets (saturating).
//   msg_ip gates downstream capture; the err/stat outputs feed status regs.
//
// Optional feature: define FRAME_TIMEOUT_EN to abort a packet that stalls
// for TIMEOUT_CYC consecutive idle cycles inside HEAD/DATA.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   bus       in   stream beat bundle (valid/head/tail), slave modport
//   state_o   out  3      IDLE=000 HEAD=001 DATA=010 TAIL=011 ERR=100
//   msg_ip    out  1      packet in progress (HEAD, DATA or TAIL)
//   beat_cnt  out  LEN_W  beats accepted in current/last packet
//   pkt_done  out  1      pulse on the cycle the FSM enters TAIL
//   pkt_err   out  1      pulse on any protocol error
//   err_code  out  3      last error: 001 STRAY 010 RESTART 011 OVERLONG 100 TIMEOUT
//   pkt_count out  CNT_W  completed packets, saturating at all-ones
//
// States
//   state | meaning
//   IDLE  | no packet open, waiting for a head beat
//   HEAD  | head beat accepted, packet open
//   DATA  | at least one body beat accepted, packet open
//   TAIL  | tail beat accepted this cycle, packet complete
//   ERR   | one-cycle abort after overlong/timeout, inputs ignored
module pkt_frame_fsm #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned LEN_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  pkt_frame_fsm_if.slave       bus,
  output logic [2:0]           state_o,
  output logic                 msg_ip,
  output logic [LEN_W-1:0]     beat_cnt,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic [2:0]           err_code,
  output logic [CNT_W-1:0]     pkt_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_HEAD = 3'b001,
    ST_DATA = 3'b010,
    ST_TAIL = 3'b011,
    ST_ERR  = 3'b100
  } state_e;

  localparam logic [2:0] ERR_STRAY    = 3'b001;
  localparam logic [2:0] ERR_RESTART  = 3'b010;
  localparam logic [2:0] ERR_OVERLONG = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  if (MAX_LEN < 2 || MAX_LEN > ((1 << LEN_W) - 1) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("pkt_frame_fsm: MAX_LEN must be >=2 and fit LEN_W; TIMEOUT_CYC must be >=1");
  end

  logic valid_i;
  logic head_i;
  logic tail_i;

  assign valid_i = bus.valid;
  assign head_i  = bus.head;
  assign tail_i  = bus.tail;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               msg_ip_q, msg_ip_d;
  logic               pkt_done_q, pkt_done_d;
  logic               pkt_err_q, pkt_err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

  logic               err_hit;
  logic [2:0]         err_kind;
  logic [LEN_W-1:0]   cnt_inc;

  assign cnt_inc = beat_cnt_q + LEN_W'(1);

`ifdef FRAME_TIMEOUT_EN
  // Idle-gap timer: down-counter reloaded to TIMEOUT_CYC whenever a beat
  // arrives or the packet is not open; terminal count 1 on an idle cycle
  // means this is the TIMEOUT_CYC-th consecutive idle cycle.
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      msg_ip_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 3'b000;
      pkt_count_q <= '0;
`ifdef FRAME_TIMEOUT_EN
      gap_q       <= GAP_W'(TIMEOUT_CYC);
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      msg_ip_q    <= msg_ip_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_count_q <= pkt_count_d;
`ifdef FRAME_TIMEOUT_EN
      gap_q       <= gap_d;
`endif
    end
  end

  // Next-state and error detection
  always_comb begin
    state_d  = state_q;
    err_hit  = 1'b0;
    err_kind = ERR_STRAY;
`ifdef FRAME_TIMEOUT_EN
    gap_d    = GAP_W'(TIMEOUT_CYC);
`endif
    case (state_q)
      ST_IDLE, ST_TAIL: begin
        state_d = ST_IDLE;
        if (valid_i) begin
          if (head_i) begin
            state_d = tail_i ? ST_TAIL : ST_HEAD;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_STRAY;
          end
        end
      end
      ST_HEAD, ST_DATA: begin
        if (!valid_i) begin
`ifdef FRAME_TIMEOUT_EN
          if (gap_q == GAP_W'(1)) begin
            state_d  = ST_ERR;
            err_hit  = 1'b1;
            err_kind = ERR_TIMEOUT;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
`endif
        end else if (head_i) begin
          // Restart wins over tail and overlong; the new packet just opens.
          state_d  = ST_HEAD;
          err_hit  = 1'b1;
          err_kind = ERR_RESTART;
        end else if (tail_i) begin
          // Tail on beat MAX_LEN is legal, so it is checked before overlong.
          state_d = ST_TAIL;
        end else if (cnt_inc == LEN_W'(MAX_LEN)) begin
          state_d  = ST_ERR;
          err_hit  = 1'b1;
          err_kind = ERR_OVERLONG;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE, ST_TAIL: begin
        if (valid_i && head_i) beat_cnt_d = LEN_W'(1);
      end
      ST_HEAD, ST_DATA: begin
        if (valid_i) beat_cnt_d = head_i ? LEN_W'(1) : cnt_inc;
      end
      default: begin
        beat_cnt_d = '0;
      end
    endcase

    msg_ip_d   = (state_d == ST_HEAD) || (state_d == ST_DATA) || (state_d == ST_TAIL);
    // TAIL never holds for two cycles without a new packet, so every cycle
    // whose next state is TAIL is a fresh completion.
    pkt_done_d = (state_d == ST_TAIL);

    pkt_count_d = pkt_count_q;
    if (pkt_done_d && (pkt_count_q != {CNT_W{1'b1}})) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
    end

    pkt_err_d  = err_hit;
    err_code_d = err_hit ? err_kind : err_code_q;
  end

  assign state_o   = state_q;
  assign msg_ip    = msg_ip_q;
  assign beat_cnt  = beat_cnt_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pkt_frame_fsm.sv
// tb_pkt_frame_fsm
//   Directed-vector bench for pkt_frame_fsm. Each driven beat pushes its
//   hand-computed expected outputs into a queue; a monitor pops and compares
//   after every rising edge. Builds with or without FRAME_TIMEOUT_EN.
module tb_pkt_frame_fsm;
  localparam int unsigned MAX_LEN     = 16;
  localparam int unsigned LEN_W       = 5;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TIMEOUT_CYC = 8;

`ifdef FRAME_TIMEOUT_EN
  localparam logic [2:0] CODE_T6 = 3'd4;
  localparam int         PC_T6   = 7;
`else
  localparam logic [2:0] CODE_T6 = 3'd2;
  localparam int         PC_T6   = 8;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       state_o;
  logic             msg_ip;
  logic [LEN_W-1:0] beat_cnt;
  logic             pkt_done;
  logic             pkt_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] pkt_count;

  always #5 clock = ~clock;

  pkt_frame_fsm_if bus_if ();

  pkt_frame_fsm #(
    .MAX_LEN    (MAX_LEN),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .state_o  (state_o),
    .msg_ip   (msg_ip),
    .beat_cnt (beat_cnt),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .pkt_count(pkt_count)
  );

  typedef struct {
    string            tag;
    logic [2:0]       st;
    logic             msg;
    logic [LEN_W-1:0] cnt;
    logic             done;
    logic             err;
    logic [2:0]       code;
    logic [CNT_W-1:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec    = 0;
  int   n_miscmp = 0;

  // Drive one beat and queue the outputs expected after the next rising edge.
  task automatic step(input string tag, input logic v, input logic h, input logic t,
                      input logic [2:0] st, input int cnt, input logic done,
                      input logic err, input logic [2:0] code, input int pc);
    exp_t e;
    @(negedge clock);
    bus_if.valid = v;
    bus_if.head  = h;
    bus_if.tail  = t;
    e.tag  = tag;
    e.st   = st;
    e.msg  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    e.cnt  = LEN_W'(cnt);
    e.done = done;
    e.err  = err;
    e.code = code;
    e.pc   = CNT_W'(pc);
    sb_q.push_back(e);
  endtask

  task automatic dchk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if (state_o !== mon_e.st || msg_ip !== mon_e.msg || beat_cnt !== mon_e.cnt ||
            pkt_done !== mon_e.done || pkt_err !== mon_e.err || err_code !== mon_e.code ||
            pkt_count !== mon_e.pc) begin
          n_miscmp++;
          $display("FAIL %s: got st=%0d msg=%0d cnt=%0d done=%0d err=%0d code=%0d pc=%0d expected st=%0d msg=%0d cnt=%0d done=%0d err=%0d code=%0d pc=%0d",
                   mon_e.tag, state_o, msg_ip, beat_cnt, pkt_done, pkt_err, err_code, pkt_count,
                   mon_e.st, mon_e.msg, mon_e.cnt, mon_e.done, mon_e.err, mon_e.code, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.valid = 1'b0;
    bus_if.head  = 1'b0;
    bus_if.tail  = 1'b0;
    reset        = 1'b1;
    #12;
    dchk("rst_state", 32'(state_o), 32'd0);
    dchk("rst_msg",   32'(msg_ip), 32'd0);
    dchk("rst_cnt",   32'(beat_cnt), 32'd0);
    dchk("rst_pulse", 32'({pkt_done, pkt_err}), 32'd0);
    dchk("rst_code",  32'(err_code), 32'd0);
    dchk("rst_pc",    32'(pkt_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Four-beat packet
    step("t1_head", 1, 1, 0, 3'd1, 1, 0, 0, 3'd0, 0);
    step("t1_d1",   1, 0, 0, 3'd2, 2, 0, 0, 3'd0, 0);
    step("t1_d2",   1, 0, 0, 3'd2, 3, 0, 0, 3'd0, 0);
    step("t1_tail", 1, 0, 1, 3'd3, 4, 1, 0, 3'd0, 1);
    step("t1_idle", 0, 0, 0, 3'd0, 4, 0, 0, 3'd0, 1);

    // Single-beat packet
    step("t2_single", 1, 1, 1, 3'd3, 1, 1, 0, 3'd0, 2);
    step("t2_idle",   0, 0, 0, 3'd0, 1, 0, 0, 3'd0, 2);

    // Overlong: 16th non-tail beat aborts; head during ERR is dropped
    step("t3_head", 1, 1, 0, 3'd1, 1, 0, 0, 3'd0, 2);
    for (int i = 2; i <= 15; i++) step("t3_data", 1, 0, 0, 3'd2, i, 0, 0, 3'd0, 2);
    step("t3_over",    1, 0, 0, 3'd4, 16, 0, 1, 3'd3, 2);
    step("t3_errhead", 1, 1, 0, 3'd0, 0, 0, 0, 3'd3, 2);
    step("t3_idle",    0, 0, 0, 3'd0, 0, 0, 0, 3'd3, 2);

    // Stray beat in IDLE
    step("t4_stray", 1, 0, 0, 3'd0, 0, 0, 1, 3'd1, 2);
    step("t4_idle",  0, 0, 0, 3'd0, 0, 0, 0, 3'd1, 2);

    // Restart mid-packet
    step("t5_head",    1, 1, 0, 3'd1, 1, 0, 0, 3'd1, 2);
    step("t5_data",    1, 0, 0, 3'd2, 2, 0, 0, 3'd1, 2);
    step("t5_restart", 1, 1, 0, 3'd1, 1, 0, 1, 3'd2, 2);
    step("t5_tail",    1, 0, 1, 3'd3, 2, 1, 0, 3'd2, 3);
    step("t5_idle",    0, 0, 0, 3'd0, 2, 0, 0, 3'd2, 3);

    // Tail exactly on beat MAX_LEN is legal
    step("ml_head", 1, 1, 0, 3'd1, 1, 0, 0, 3'd2, 3);
    for (int i = 2; i <= 15; i++) step("ml_data", 1, 0, 0, 3'd2, i, 0, 0, 3'd2, 3);
    step("ml_tail", 1, 0, 1, 3'd3, 16, 1, 0, 3'd2, 4);

    // Stray beat straight after TAIL
    step("tl_stray", 1, 0, 0, 3'd0, 16, 0, 1, 3'd1, 4);
    step("tl_idle",  0, 0, 0, 3'd0, 16, 0, 0, 3'd1, 4);

    // Back-to-back single-beat packets
    step("bb_1", 1, 1, 1, 3'd3, 1, 1, 0, 3'd1, 5);
    step("bb_2", 1, 1, 1, 3'd3, 1, 1, 0, 3'd1, 6);

    // Head+tail inside a packet: restart takes priority over tail
    step("pr_head",    1, 1, 0, 3'd1, 1, 0, 0, 3'd1, 6);
    step("pr_restart", 1, 1, 1, 3'd1, 1, 0, 1, 3'd2, 6);
    step("pr_tail",    1, 0, 1, 3'd3, 2, 1, 0, 3'd2, 7);
    step("pr_idle",    0, 0, 0, 3'd0, 2, 0, 0, 3'd2, 7);

    // Idle gap inside a packet
    step("t6_head", 1, 1, 0, 3'd1, 1, 0, 0, 3'd2, 7);
    for (int i = 1; i <= 7; i++) step("t6_gap", 0, 0, 0, 3'd1, 1, 0, 0, 3'd2, 7);
`ifdef FRAME_TIMEOUT_EN
    step("t6_timeout", 0, 0, 0, 3'd4, 1, 0, 1, 3'd4, 7);
    step("t6_idle",    0, 0, 0, 3'd0, 0, 0, 0, 3'd4, 7);
`else
    step("t6_gap8", 0, 0, 0, 3'd1, 1, 0, 0, 3'd2, 7);
    step("t6_gap9", 0, 0, 0, 3'd1, 1, 0, 0, 3'd2, 7);
    step("t6_tail", 1, 0, 1, 3'd3, 2, 1, 0, 3'd2, 8);
    step("t6_idle", 0, 0, 0, 3'd0, 2, 0, 0, 3'd2, 8);
`endif

    // Asynchronous reset while in DATA
    step("rs_head", 1, 1, 0, 3'd1, 1, 0, 0, CODE_T6, PC_T6);
    step("rs_data", 1, 0, 0, 3'd2, 2, 0, 0, CODE_T6, PC_T6);
    @(posedge clock);
    #3;
    bus_if.valid = 1'b0;
    bus_if.head  = 1'b0;
    reset = 1'b1;
    #1;
    dchk("arst_state", 32'(state_o), 32'd0);
    dchk("arst_msg",   32'(msg_ip), 32'd0);
    dchk("arst_cnt",   32'(beat_cnt), 32'd0);
    dchk("arst_pulse", 32'({pkt_done, pkt_err}), 32'd0);
    dchk("arst_code",  32'(err_code), 32'd0);
    dchk("arst_pc",    32'(pkt_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step("rs_after", 1, 1, 0, 3'd1, 1, 0, 0, 3'd0, 0);
    step("rs_idle",  0, 0, 0, 3'd1, 1, 0, 0, 3'd0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miscmp++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
